// File: rtl/echo_delay_mc.sv
// rtl/echo_delay_mc.sv - multi-channel feedback echo over a shared 2-cycle multiplier; optional wet mix via ECHO_MIX_EN
module echo_delay_mc #(
  parameter int WIDTH      = 24,
  parameter int CHANNELS   = 2,
  parameter int MAX_LENGTH = 9600,
  localparam int DW = $clog2(MAX_LENGTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      finish,
  input  logic [DW-1:0]             delay_len,
  input  logic [8:0]                fb,
`ifdef ECHO_MIX_EN
  input  logic [8:0]                mix,
`endif
  input  logic [CHANNELS*WIDTH-1:0] in,
  output logic [CHANNELS*WIDTH-1:0] out,
  output logic [31:0]               mult_a,
  output logic [31:0]               mult_b,
  input  logic [63:0]               mult_p
);

  localparam int AW = $clog2(CHANNELS * MAX_LENGTH);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [DW-1:0] MAX_L = DW'(MAX_LENGTH);

`ifdef ECHO_MIX_EN
  // MIX1 doubles as the wait cycle for the feedback product; the mix product is captured in MIX2
  typedef enum logic [3:0] {IDLE, READ, MUL1, MIX1, ACC, MIX2, WB, FINISH} state_t;
`else
  typedef enum logic [3:0] {IDLE, READ, MUL1, MUL2, ACC, FINISH} state_t;
`endif

  state_t state, state_nxt;

  logic [CHANNELS*WIDTH-1:0] in_r;
  logic [8:0]                fb_r;
  logic [DW-1:0]             dl_r;
  logic [DW-1:0]             wr_ptr;
  logic [DW-1:0]             fill;
  logic [CW-1:0]             ch;
  logic [WIDTH-1:0]          ram [CHANNELS*MAX_LENGTH];
  logic [WIDTH-1:0]          ram_rdata;
  logic [DW:0]               rd_sum;
  logic [DW:0]               rd_frame;
  logic [AW-1:0]             rd_addr;
  logic [AW-1:0]             wr_addr;
  logic [WIDTH-1:0]          d_cur;
  logic [WIDTH-1:0]          x_cur;
  logic [WIDTH-1:0]          y_cur;
  logic                      last_ch;
  logic                      unused_mult_p_bits;
`ifdef ECHO_MIX_EN
  logic [8:0]                mix_r;
  logic [WIDTH-1:0]          d_r;
  logic [WIDTH-1:0]          mixp_r;
`endif

  function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH:0] s;
    s = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    if (s[WIDTH] != s[WIDTH-1])
      return s[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    return s[WIDTH-1:0];
  endfunction

  // Ring arithmetic: delayed frame slot is (wr_ptr - dl) mod MAX_LENGTH, computed without a divider
  assign rd_sum   = {1'b0, wr_ptr} + (DW+1)'(MAX_LENGTH) - {1'b0, dl_r};
  assign rd_frame = (rd_sum >= (DW+1)'(MAX_LENGTH)) ? rd_sum - (DW+1)'(MAX_LENGTH) : rd_sum;
  assign rd_addr  = AW'(32'(rd_frame) * CHANNELS + 32'(ch));
  assign wr_addr  = AW'(32'(wr_ptr) * CHANNELS + 32'(ch));
  assign d_cur    = (dl_r == '0 || fill < dl_r) ? '0 : ram_rdata;
  assign x_cur    = in_r[32'(ch)*WIDTH +: WIDTH];
  assign y_cur    = sat_add(x_cur, mult_p[WIDTH+7:8]);
  assign last_ch  = (ch == CW'(CHANNELS - 1));
  assign unused_mult_p_bits = ^{mult_p[63:WIDTH+8], mult_p[7:0]};

  // Delay RAM: synchronous read, feedback sum written back in ACC
  always_ff @(posedge clk) begin
    if (state == ACC) ram[wr_addr] <= y_cur;
    ram_rdata <= ram[rd_addr];
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state, finish pulse and multiplier operands
  always_comb begin
    state_nxt = state;
    finish    = 1'b0;
    mult_a    = '0;
    mult_b    = '0;
    case (state)
      IDLE:   if (start) state_nxt = READ;
      READ:   state_nxt = MUL1;
      MUL1: begin
        mult_a = {{23{fb_r[8]}}, fb_r};
        mult_b = {{(32-WIDTH){d_cur[WIDTH-1]}}, d_cur};
`ifdef ECHO_MIX_EN
        state_nxt = MIX1;
`else
        state_nxt = MUL2;
`endif
      end
`ifdef ECHO_MIX_EN
      MIX1: begin
        mult_a    = {{23{mix_r[8]}}, mix_r};
        mult_b    = {{(32-WIDTH){d_r[WIDTH-1]}}, d_r};
        state_nxt = ACC;
      end
      ACC:    state_nxt = MIX2;
      MIX2:   state_nxt = WB;
      WB:     state_nxt = last_ch ? FINISH : READ;
`else
      MUL2:   state_nxt = ACC;
      ACC:    state_nxt = last_ch ? FINISH : READ;
`endif
      FINISH: begin
        finish    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Frame datapath: latch inputs, produce per-channel results, advance ring pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      in_r   <= '0;
      fb_r   <= '0;
      dl_r   <= '0;
      wr_ptr <= '0;
      fill   <= '0;
      ch     <= '0;
      out    <= '0;
`ifdef ECHO_MIX_EN
      mix_r  <= '0;
      d_r    <= '0;
      mixp_r <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          in_r <= in;
          fb_r <= fb;
          dl_r <= (delay_len > MAX_L) ? MAX_L : delay_len;
          ch   <= '0;
`ifdef ECHO_MIX_EN
          mix_r <= mix;
`endif
        end
`ifdef ECHO_MIX_EN
        MUL1: d_r <= d_cur;
        MIX2: mixp_r <= mult_p[WIDTH+7:8];
        WB: begin
          out[32'(ch)*WIDTH +: WIDTH] <= sat_add(x_cur, mixp_r);
          ch <= ch + 1'b1;
        end
`else
        ACC: begin
          out[32'(ch)*WIDTH +: WIDTH] <= y_cur;
          ch <= ch + 1'b1;
        end
`endif
        FINISH: begin
          wr_ptr <= (wr_ptr == DW'(MAX_LENGTH - 1)) ? '0 : wr_ptr + 1'b1;
          if (fill != MAX_L) fill <= fill + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_echo_delay_mc.sv
// tb/tb_echo_delay_mc.sv - scoreboard bench for echo_delay_mc against a frame-history reference model
module tb_echo_delay_mc;
  localparam int W  = 24;
  localparam int C  = 2;
  localparam int M  = 8;
  localparam int DW = $clog2(M + 1);
`ifdef ECHO_MIX_EN
  localparam int LAT = 6 * C + 1;
  localparam bit MIXB = 1'b1;
`else
  localparam int LAT = 4 * C + 1;
  localparam bit MIXB = 1'b0;
`endif

  typedef longint frame_t [C];

  logic              clk = 1'b0;
  logic              rst, start, finish;
  logic [DW-1:0]     delay_len;
  logic [8:0]        fb, mix;
  logic [C*W-1:0]    in, out;
  logic [31:0]       mult_a, mult_b;
  logic [63:0]       mult_p;
  logic signed [63:0] p1, p2;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  logic [C*W-1:0] exp_q[$];
  int             exp_t[$];
  frame_t         hist[$];

  echo_delay_mc #(.WIDTH(W), .CHANNELS(C), .MAX_LENGTH(M)) dut (
    .clk(clk), .rst(rst), .start(start), .finish(finish),
    .delay_len(delay_len), .fb(fb),
`ifdef ECHO_MIX_EN
    .mix(mix),
`endif
    .in(in), .out(out), .mult_a(mult_a), .mult_b(mult_b), .mult_p(mult_p)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Shared multiplier: 2-cycle signed product
  always @(posedge clk) begin
    p1 <= $signed(mult_a) * $signed(mult_b);
    p2 <= p1;
  end
  assign mult_p = p2;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor: every finish pops one expected frame and its expected finish cycle
  always @(negedge clk) begin
    if (finish) begin
      if (exp_q.size() == 0) check("unexpected_finish", 64'd1, 64'd0);
      else begin
        check("out", 64'(out), 64'(exp_q.pop_front()));
        check("finish_cycle", 64'(cyc), 64'(exp_t.pop_front()));
      end
    end
  end

  function automatic longint sat(input longint v);
    longint hi, lo;
    hi = (longint'(1) <<< (W - 1)) - 1;
    lo = -(longint'(1) <<< (W - 1));
    return (v > hi) ? hi : (v < lo) ? lo : v;
  endfunction

  function automatic longint gain(input int g);
    logic signed [8:0] s;
    s = 9'(g);
    return longint'(s);
  endfunction

  function automatic longint rnd_s();
    logic signed [W-1:0] r;
    r = W'($urandom);
    return longint'(r);
  endfunction

  // One frame: model expectation, drive start, then hold for the frame period
  task automatic run_frame(input longint x0, input longint x1, input int dl, input int g,
                           input int mx, input bit stray, input bit abort);
    frame_t x, y;
    logic [C*W-1:0] o;
    longint d;
    int k, dle;
    x[0] = x0; x[1] = x1;
    k   = hist.size();
    dle = (dl > M) ? M : dl;
    for (int c = 0; c < C; c++) begin
      d    = (dle != 0 && k >= dle) ? hist[k - dle][c] : 0;
      y[c] = sat(x[c] + ((gain(g) * d) >>> 8));
      o[c*W +: W] = MIXB ? W'(sat(x[c] + ((gain(mx) * d) >>> 8))) : W'(y[c]);
    end
    if (abort) hist.delete();
    else begin
      hist.push_back(y);
      exp_q.push_back(o);
      exp_t.push_back(cyc + LAT);
    end
    start     = 1'b1;
    delay_len = DW'(dl);
    fb        = 9'(g);
    mix       = 9'(mx);
    in        = {x1[W-1:0], x0[W-1:0]};
    for (int i = 1; i <= LAT + 1; i++) begin
      @(negedge clk);
      start = stray && (i == 3);
      if (i == 1) begin
        in = {W'($urandom), W'($urandom)};
        fb = 9'($urandom); mix = 9'($urandom); delay_len = DW'($urandom);
      end
      if (abort && i == 5) rst = 1'b1;
      if (abort && i == 6) begin
        rst = 1'b0;
        check("abort_out", 64'(out), 64'd0);
        check("abort_finish", 64'(finish), 64'd0);
      end
    end
  endtask

  task automatic test_warmup();
    run_frame(100, -50, 3, 128, 0, 0, 0);
    for (int f = 1; f < 7; f++) run_frame(0, 0, 3, 128, 0, 0, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; delay_len = '0; fb = '0; mix = '0; in = '0;
    repeat (3) @(negedge clk);
    check("reset_finish", 64'(finish), 64'd0);
    check("reset_out", 64'(out), 64'd0);
    check("reset_mult_a", 64'(mult_a), 64'd0);
    check("reset_mult_b", 64'(mult_b), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    test_warmup();
    run_frame(rnd_s(), rnd_s(), 3, 100, 0, 1, 0);
    run_frame(0, 0, 3, 100, 0, 1, 0);

    // saturation toward both rails
    run_frame(64'sh7FFFF0, -64'sh7FFFF0, 1, 255, 0, 0, 0);
    run_frame(64'sh7FFFF0, -64'sh7FFFF0, 1, 255, 0, 0, 0);
    run_frame(0, 0, 1, 255, 0, 0, 0);

    // ring wrap at full depth, then out-of-range delay clamped
    run_frame(1000, 0, 8, 128, 0, 0, 0);
    for (int f = 0; f < 24; f++) run_frame(0, 0, 8, 128, 0, 0, 0);
    for (int f = 0; f < 10; f++) run_frame(rnd_s(), rnd_s(), 15, -90, 0, 0, 0);

    // bypass
    for (int f = 0; f < 20; f++) run_frame(rnd_s(), rnd_s(), 0, int'($urandom_range(0, 511)), 0, 0, 0);

    // random delays, gains and mixes
    for (int f = 0; f < 30; f++)
      run_frame(rnd_s(), rnd_s(), int'($urandom_range(0, 10)), int'($urandom_range(0, 511)),
                int'($urandom_range(0, 511)), 0, 0);

    // mid-frame reset then fresh warm-up with no stale echo
    run_frame(rnd_s(), rnd_s(), 2, 200, 0, 0, 1);
    repeat (LAT) @(negedge clk);
    test_warmup();

`ifdef ECHO_MIX_EN
    rst = 1'b1; @(negedge clk); rst = 1'b0; hist.delete(); @(negedge clk);
    run_frame(400, 0, 2, 0, 64, 0, 0);
    for (int f = 0; f < 4; f++) run_frame(0, 0, 2, 0, 64, 0, 0);
`endif

    repeat (LAT + 3) @(negedge clk);
    check("drain_pending", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
